tpu_top: RTL and testbench

Memory-mapped 4×4 (parameterizable N×N) unsigned integer matrix-multiply accelerator computing C = A·B on an output-stationary systolic MAC array. It sits on the SoC's 16-bit-address MMIO bus as a slave. Firmware loads operand matrices A and B, starts the engine through CTRL, polls STATUS, and reads C.

---
 rtl/tpu_top.sv | 206 ++++++++++++++++++++
 tb/tb_tpu_top.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_top.sv
// tpu_top: MMIO-attached N x N output-stationary systolic matrix multiplier computing C = A*B.
// Operands are streamed into the array with a diagonal skew; finished sums are copied into C.
module tpu_top #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    input  logic [15:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic [3:0]  mmio_wstrb,
    output logic [31:0] mmio_rdata,
    output logic        mmio_ready
);

    localparam int             NN      = N * N;
    localparam int             IDX_W   = $clog2(NN);
    localparam int             T_W     = $clog2(3 * N);
    localparam logic [T_W-1:0] T_LAST  = T_W'(3 * N - 2);
    localparam logic [31:0]    ID_VAL  = 32'h5450_5531;
    localparam logic [31:0]    VER_VAL = 32'h0001_0000;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE, S_DONE} state_e;

    state_e           state_q;
    logic [T_W-1:0]   t_ctr_q;
    logic             busy_q;
    logic             done_q;
    logic             capture_sums;

    logic [DATA_W-1:0] a_mem_q [NN];
    logic [DATA_W-1:0] b_mem_q [NN];
    logic [SUM_W-1:0]  c_mem_q [NN];

    logic [SUM_W-1:0]  acc_q [N][N];
    logic [DATA_W-1:0] a_q   [N][N];
    logic [DATA_W-1:0] b_q   [N][N];
    logic [DATA_W-1:0] a_in  [N][N];
    logic [DATA_W-1:0] b_in  [N][N];
    logic [SUM_W-1:0]  prod  [N][N];
    logic [DATA_W-1:0] feed_a [N];
    logic [DATA_W-1:0] feed_b [N];

    logic             a_hit, b_hit, c_hit, op_wr, start_wr;
    logic [IDX_W-1:0] ab_idx, c_idx;
    logic             unused_bits;

    assign mmio_ready   = 1'b1;
    assign capture_sums = (state_q == S_CAPTURE);

    assign a_hit    = (mmio_addr[15:8] == 8'h01) && (int'(mmio_addr[7:0]) < NN);
    assign b_hit    = (mmio_addr[15:8] == 8'h02) && (int'(mmio_addr[7:0]) < NN);
    assign c_hit    = (mmio_addr[15:8] == 8'h03) && (mmio_addr[1:0] == 2'b00) &&
                      (int'(mmio_addr[7:2]) < NN);
    assign ab_idx   = mmio_addr[IDX_W-1:0];
    assign c_idx    = mmio_addr[IDX_W+1:2];
    assign op_wr    = mmio_wr && mmio_wstrb[0] && !busy_q;
    assign start_wr = mmio_wr && mmio_wstrb[0] && mmio_wdata[0] && (mmio_addr == 16'h0008);

    assign unused_bits = ^{mmio_wdata[31:DATA_W], mmio_wstrb[3:1]};

    // Skewed feed: row r / column c enters k cycles after the wavefront reaches it (t = r + k).
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        for (int i = 0; i < N; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
        end
        if (state_q == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_ctr_q) == i + k) begin
                        feed_a[i] = a_mem_q[i*N + k];
                        feed_b[i] = b_mem_q[k*N + i];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_in[r][c] = feed_a[r];
            end else begin : g_a_inner
                assign a_in[r][c] = a_q[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in[r][c] = feed_b[c];
            end else begin : g_b_inner
                assign b_in[r][c] = b_q[r-1][c];
            end
            assign prod[r][c] = SUM_W'(a_in[r][c]) * SUM_W'(b_in[r][c]);
        end
    end

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    acc_q[r][c] <= '0;
                    a_q[r][c]   <= '0;
                    b_q[r][c]   <= '0;
                end
            end
        end else if (state_q == S_CLEAR) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    acc_q[r][c] <= '0;
                    a_q[r][c]   <= '0;
                    b_q[r][c]   <= '0;
                end
            end
        end else if (state_q == S_RUN) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    acc_q[r][c] <= acc_q[r][c] + prod[r][c];
                    a_q[r][c]   <= a_in[r][c];
                    b_q[r][c]   <= b_in[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the operand and result arrays are architecturally visible, so they are reset
            // explicitly rather than left as uninitialised RAM.
            for (int i = 0; i < NN; i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
                c_mem_q[i] <= '0;
            end
        end else begin
            if (op_wr && a_hit) a_mem_q[ab_idx] <= mmio_wdata[DATA_W-1:0];
            if (op_wr && b_hit) b_mem_q[ab_idx] <= mmio_wdata[DATA_W-1:0];
            if (capture_sums) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        c_mem_q[r*N + c] <= acc_q[r][c];
                    end
                end
            end
        end
    end

    // The spare t = 3N-2 cycle of the count is spent in CAPTURE while the sums are copied out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_ctr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_wr) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_RUN;
                    t_ctr_q <= '0;
                end
                S_RUN: begin
                    t_ctr_q <= t_ctr_q + 1'b1;
                    if (t_ctr_q == T_LAST - 1'b1) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_q <= S_DONE;
                    t_ctr_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mmio_rdata = '0;
        if (mmio_rd) begin
            if (a_hit) begin
                mmio_rdata = 32'(a_mem_q[ab_idx]);
            end else if (b_hit) begin
                mmio_rdata = 32'(b_mem_q[ab_idx]);
            end else if (c_hit) begin
                mmio_rdata = 32'(c_mem_q[c_idx]);
            end else begin
                case (mmio_addr)
                    16'h0000: mmio_rdata = ID_VAL;
                    16'h0004: mmio_rdata = VER_VAL;
                    16'h000C: mmio_rdata = {30'b0, done_q, busy_q};
                    default:  mmio_rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu_top.sv
// Self-checking bench for tpu_top: randomized operands checked against a plain
// matrix-product model, plus register map, timing and reset behaviour.
module tb_tpu_top;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mmio_wr = 1'b0;
    logic        mmio_rd = 1'b0;
    logic [15:0] mmio_addr = '0;
    logic [31:0] mmio_wdata = '0;
    logic [3:0]  mmio_wstrb = '0;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;

    always #5 clk = ~clk;

    tpu_top #(.N(N), .DATA_W(8), .SUM_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_wr    (mmio_wr),
        .mmio_rd    (mmio_rd),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_wstrb (mmio_wstrb),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cap_cnt = 0;

    logic [7:0]  ma [NN];
    logic [7:0]  mb [NN];
    logic [31:0] mc [NN];

    always @(negedge clk) if (dut.capture_sums) cap_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Tasks start just after a falling edge and return just after the next one.
    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        mmio_wr    = 1'b1;
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_wstrb = s;
        @(negedge clk);
        mmio_wr    = 1'b0;
        mmio_wstrb = '0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        mmio_rd   = 1'b1;
        mmio_addr = a;
        #1;
        d = mmio_rdata;
        mmio_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_a(input int i, input logic [7:0] v);
        bus_wr(16'h0100 + 16'(i), {24'h0, v}, 4'h1);
        ma[i] = v;
    endtask

    task automatic load_b(input int i, input logic [7:0] v);
        bus_wr(16'h0200 + 16'(i), {24'h0, v}, 4'h1);
        mb[i] = v;
    endtask

    function automatic void compute_model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [31:0] s;
                s = 0;
                for (int k = 0; k < N; k++) s += 32'(ma[r*N + k]) * 32'(mb[k*N + c]);
                mc[r*N + c] = s;
            end
        end
    endfunction

    task automatic check_c(input string tag);
        logic [31:0] d;
        for (int i = 0; i < NN; i++) begin
            bus_rd(16'h0300 + 16'(4 * i), d);
            check($sformatf("%s C[%0d]", tag, i), d, mc[i]);
        end
    endtask

    task automatic run_and_check(input string tag, input bit disturb);
        logic [31:0] st;
        int cyc;
        compute_model();
        cap_cnt = 0;
        st = '0;
        bus_wr(16'h0008, 32'h1, 4'h1);
        for (cyc = 0; cyc < 200; cyc++) begin
            if (disturb && cyc == 3) begin
                bus_wr(16'h0008, 32'h1, 4'h1);
            end else if (disturb && cyc == 4) begin
                bus_wr(16'h0100, 32'h77, 4'h1);
            end else begin
                bus_rd(16'h000C, st);
                if (cyc == 0) check({tag, " status after start"}, st, 32'h1);
                if (st[0] == 1'b0) break;
            end
        end
        check({tag, " busy cycles"}, 32'(cyc), 32'(3 * N));
        check({tag, " status done"}, st, 32'h2);
        check({tag, " capture pulses"}, 32'(cap_cnt), 32'd1);
        check_c(tag);
    endtask

    task automatic load_random();
        for (int i = 0; i < NN; i++) load_a(i, 8'($urandom_range(0, 255)));
        for (int i = 0; i < NN; i++) load_b(i, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] sum;
        logic [7:0]  spec_a [NN];
        logic [7:0]  spec_b [NN];
        spec_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        spec_b = '{2, 1, 0, 3, 1, 0, 2, 1, 3, 1, 1, 0, 0, 2, 1, 1};

        repeat (2) @(negedge clk);
        check("reset ready", 32'(mmio_ready), 32'd1);
        check("reset rdata", mmio_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        bus_rd(16'h0000, d); check("ID", d, 32'h5450_5531);
        bus_rd(16'h0004, d); check("VER", d, 32'h0001_0000);
        bus_rd(16'h000C, d); check("reset STATUS", d, 32'h0);
        bus_rd(16'h0300, d); check("reset C[0]", d, 32'h0);
        bus_rd(16'h0100, d); check("reset A[0]", d, 32'h0);
        bus_rd(16'h0008, d); check("CTRL reads 0", d, 32'h0);

        for (int i = 0; i < NN; i++) load_a(i, spec_a[i]);
        for (int i = 0; i < NN; i++) load_b(i, spec_b[i]);
        bus_rd(16'h0100, d); check("A[0] readback", d, 32'd1);
        bus_rd(16'h0200, d); check("B[0] readback", d, 32'd2);
        bus_rd(16'h010F, d); check("A[15] readback", d, 32'd16);
        run_and_check("spec", 1'b0);
        sum = 0;
        for (int i = 0; i < NN; i++) begin
            bus_rd(16'h0300 + 16'(4 * i), d);
            sum += d;
        end
        check("spec checksum", sum, 32'h27C);
        bus_rd(16'h0304, d); check("spec C[0][1]", d, 32'd12);
        bus_rd(16'h033C, d); check("spec C[3][3]", d, 32'd69);

        bus_wr(16'h0110, 32'h55, 4'h1);
        bus_rd(16'h0110, d); check("A out-of-range read", d, 32'h0);
        bus_wr(16'h0101, 32'h99, 4'h2);
        bus_rd(16'h0101, d); check("A write without strb0", d, 32'(ma[1]));
        bus_wr(16'h0300, 32'h1234, 4'hF);
        bus_rd(16'h0300, d); check("C is read-only", d, mc[0]);
        bus_wr(16'h0008, 32'h1, 4'h2);
        bus_rd(16'h000C, d); check("start without strb0", d, 32'h2);

        for (int i = 0; i < NN; i++) begin
            load_a(i, 8'hFF);
            load_b(i, 8'hFF);
        end
        run_and_check("all255", 1'b0);
        bus_rd(16'h0314, d); check("all255 C[5] literal", d, 32'h0003_F804);

        load_random();
        run_and_check("disturb", 1'b1);
        bus_rd(16'h0100, d); check("A[0] unchanged by busy write", d, 32'(ma[0]));

        for (int i = 0; i < NN; i++) load_a(i, (i % (N + 1) == 0) ? 8'd1 : 8'd0);
        for (int i = 0; i < NN; i++) load_b(i, spec_b[i]);
        run_and_check("identity", 1'b0);
        bus_rd(16'h0300, d); check("identity C[0] equals B[0]", d, 32'd2);

        for (int t = 0; t < 3; t++) begin
            load_random();
            run_and_check($sformatf("random%0d", t), 1'b0);
        end

        load_random();
        bus_wr(16'h0008, 32'h1, 4'h1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #2;
        bus_rd(16'h000C, d); check("STATUS in mid-run reset", d, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < NN; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        compute_model();
        bus_rd(16'h000C, d); check("STATUS after mid-run reset", d, 32'h0);
        bus_rd(16'h0100, d); check("A[0] after mid-run reset", d, 32'h0);
        check_c("after reset");
        load_random();
        run_and_check("post-reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
